// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer and its users.
package reorder_buffer_pkg;

  localparam int unsigned ROB_SIZE  = 16;
  localparam int unsigned ROB_IDX_W = 4;

  typedef logic [ROB_IDX_W-1:0] rob_index_t;
  typedef logic [ROB_IDX_W:0]   rob_count_t;
  typedef logic [4:0]           reg_index_t;
  typedef logic [31:0]          data_t;
  typedef logic [31:0]          addr_t;

  // Index 0 means "no dependency" and is never allocated.
  localparam rob_index_t ROB_NULL_INDEX  = '0;
  localparam rob_index_t ROB_FIRST_INDEX = rob_index_t'(1);
  localparam rob_index_t ROB_LAST_INDEX  = rob_index_t'(ROB_SIZE - 1);
  localparam rob_count_t ROB_CAPACITY    = rob_count_t'(ROB_SIZE - 1);

  typedef struct packed {
    logic       busy;
    logic       ready;
    reg_index_t rd;
    data_t      val;
    logic       is_branch;
    logic       pred_taken;
    logic       actual_taken;
    addr_t      alt_pc;
  } rob_entry_t;

  typedef struct packed {
    logic  ready;
    data_t val;
  } rob_query_t;

  // Pointer increment that skips the reserved null index.
  function automatic rob_index_t rob_next(input rob_index_t idx);
    return (idx == ROB_LAST_INDEX) ? ROB_FIRST_INDEX : idx + 1'b1;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, result, query and commit signals between the core and the reorder buffer.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  // Issue
  logic       issue_valid;
  reg_index_t issue_rd;
  logic       issue_is_branch;
  logic       issue_pred_taken;
  addr_t      issue_alt_pc;
  logic       rob_full;
  rob_index_t rob_alloc_index;

  // Result buses
  logic       alu_valid;
  rob_index_t alu_rob_index;
  data_t      alu_val;
  logic       alu_taken;
  logic       lsb_valid;
  rob_index_t lsb_rob_index;
  data_t      lsb_val;

  // Operand lookup
  rob_index_t q1_index;
  rob_index_t q2_index;
  logic       q1_ready;
  logic       q2_ready;
  data_t      q1_val;
  data_t      q2_val;

  // Commit and flush
  logic       rob_to_reg_commit;
  rob_index_t rob_to_reg_rob_index;
  reg_index_t rob_to_reg_index;
  data_t      rob_to_reg_val;
  rob_index_t rob_head_index;
  logic       rob_flush;
  addr_t      rob_flush_pc;

  modport master (
    output issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
    output alu_valid, alu_rob_index, alu_val, alu_taken,
    output lsb_valid, lsb_rob_index, lsb_val,
    output q1_index, q2_index,
    input  rob_full, rob_alloc_index, q1_ready, q2_ready, q1_val, q2_val,
    input  rob_to_reg_commit, rob_to_reg_rob_index, rob_to_reg_index, rob_to_reg_val,
    input  rob_head_index, rob_flush, rob_flush_pc
  );

  modport slave (
    input  issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
    input  alu_valid, alu_rob_index, alu_val, alu_taken,
    input  lsb_valid, lsb_rob_index, lsb_val,
    input  q1_index, q2_index,
    output rob_full, rob_alloc_index, q1_ready, q2_ready, q1_val, q2_val,
    output rob_to_reg_commit, rob_to_reg_rob_index, rob_to_reg_index, rob_to_reg_val,
    output rob_head_index, rob_flush, rob_flush_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates slots at issue, captures ALU/LSB results,
// retires one entry per cycle and flushes everything on a branch mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input logic             clk_in,
  input logic             rst_in,
  input logic             rdy_in,
  reorder_buffer_if.slave bus
);

  rob_entry_t entry_q [ROB_SIZE];
  rob_entry_t entry_d [ROB_SIZE];
  rob_index_t head_q, head_d;
  rob_index_t tail_q, tail_d;
  rob_count_t count_q, count_d;

  logic       commit_q, commit_d;
  rob_index_t commit_idx_q, commit_idx_d;
  reg_index_t commit_rd_q, commit_rd_d;
  data_t      commit_val_q, commit_val_d;
  logic       flush_q, flush_d;
  addr_t      flush_pc_q, flush_pc_d;

  rob_entry_t head_entry;
  logic       full, issue_fire;
  logic       alu_hit_head, lsb_hit_head;
  logic       head_ready, head_taken;
  data_t      head_val;
  logic       do_commit, mispredict;
  rob_query_t q1, q2;

  // Ready/value as seen by a consumer this cycle, bypassing the result buses.
  function automatic rob_query_t rob_lookup(
    input rob_index_t idx,
    input rob_entry_t e,
    input logic       av,
    input rob_index_t ai,
    input data_t      ad,
    input logic       lv,
    input rob_index_t li,
    input data_t      ld
  );
    rob_query_t r;
    r = '0;
    if (idx != ROB_NULL_INDEX) begin
      if (av && ai == idx) begin
        r = '{ready: 1'b1, val: ad};
      end else if (lv && li == idx) begin
        r = '{ready: 1'b1, val: ld};
      end else begin
        r = '{ready: e.ready, val: e.val};
      end
    end
    return r;
  endfunction

  assign full       = (count_q == ROB_CAPACITY);
  assign issue_fire = bus.issue_valid && !full;
  assign head_entry = entry_q[head_q];

  // Head may retire in the same cycle its result arrives, hence the bus bypass here.
  assign alu_hit_head = bus.alu_valid && (bus.alu_rob_index == head_q);
  assign lsb_hit_head = bus.lsb_valid && (bus.lsb_rob_index == head_q);
  assign head_ready   = head_entry.ready || alu_hit_head || lsb_hit_head;
  assign head_val     = alu_hit_head ? bus.alu_val :
                        lsb_hit_head ? bus.lsb_val : head_entry.val;
  assign head_taken   = alu_hit_head ? bus.alu_taken : head_entry.actual_taken;
  assign do_commit    = head_entry.busy && head_ready;
  assign mispredict   = do_commit && head_entry.is_branch &&
                        (head_taken != head_entry.pred_taken);

  assign q1 = rob_lookup(bus.q1_index, entry_q[bus.q1_index], bus.alu_valid,
                         bus.alu_rob_index, bus.alu_val, bus.lsb_valid,
                         bus.lsb_rob_index, bus.lsb_val);
  assign q2 = rob_lookup(bus.q2_index, entry_q[bus.q2_index], bus.alu_valid,
                         bus.alu_rob_index, bus.alu_val, bus.lsb_valid,
                         bus.lsb_rob_index, bus.lsb_val);

  // Next-state: result capture, issue, retirement, and wholesale invalidation on mispredict.
  always_comb begin
    entry_d      = entry_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    commit_d     = do_commit;
    commit_idx_d = commit_idx_q;
    commit_rd_d  = commit_rd_q;
    commit_val_d = commit_val_q;
    flush_d      = mispredict;
    flush_pc_d   = flush_pc_q;

    if (do_commit) begin
      commit_idx_d = head_q;
      commit_rd_d  = head_entry.rd;
      commit_val_d = head_val;
    end

    if (mispredict) begin
      // Same-cycle issue and results belong to the wrong path and are dropped.
      flush_pc_d = head_entry.alt_pc;
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
        entry_d[i].busy  = 1'b0;
        entry_d[i].ready = 1'b0;
      end
      head_d  = ROB_FIRST_INDEX;
      tail_d  = ROB_FIRST_INDEX;
      count_d = '0;
    end else begin
      if (bus.alu_valid && entry_q[bus.alu_rob_index].busy) begin
        entry_d[bus.alu_rob_index].ready        = 1'b1;
        entry_d[bus.alu_rob_index].val          = bus.alu_val;
        entry_d[bus.alu_rob_index].actual_taken = bus.alu_taken;
      end
      // ALU wins if both buses target one slot.
      if (bus.lsb_valid && entry_q[bus.lsb_rob_index].busy &&
          !(bus.alu_valid && (bus.alu_rob_index == bus.lsb_rob_index))) begin
        entry_d[bus.lsb_rob_index].ready = 1'b1;
        entry_d[bus.lsb_rob_index].val   = bus.lsb_val;
      end
      if (issue_fire) begin
        entry_d[tail_q] = '{busy:         1'b1,
                            ready:        1'b0,
                            rd:           bus.issue_rd,
                            val:          '0,
                            is_branch:    bus.issue_is_branch,
                            pred_taken:   bus.issue_pred_taken,
                            actual_taken: 1'b0,
                            alt_pc:       bus.issue_alt_pc};
        tail_d = rob_next(tail_q);
      end
      if (do_commit) begin
        entry_d[head_q].busy  = 1'b0;
        entry_d[head_q].ready = 1'b0;
        head_d = rob_next(head_q);
      end
      count_d = count_q + rob_count_t'(issue_fire) - rob_count_t'(do_commit);
    end
  end

  // State registers; rdy_in low holds everything, including the pending commit/flush pulse.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      entry_q      <= '{default: '0};
      head_q       <= ROB_FIRST_INDEX;
      tail_q       <= ROB_FIRST_INDEX;
      count_q      <= '0;
      commit_q     <= 1'b0;
      commit_idx_q <= '0;
      commit_rd_q  <= '0;
      commit_val_q <= '0;
      flush_q      <= 1'b0;
      flush_pc_q   <= '0;
    end else if (rdy_in) begin
      entry_q      <= entry_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      commit_q     <= commit_d;
      commit_idx_q <= commit_idx_d;
      commit_rd_q  <= commit_rd_d;
      commit_val_q <= commit_val_d;
      flush_q      <= flush_d;
      flush_pc_q   <= flush_pc_d;
    end
  end

  assign bus.rob_full             = full;
  assign bus.rob_alloc_index      = tail_q;
  assign bus.rob_head_index       = head_q;
  assign bus.q1_ready             = q1.ready;
  assign bus.q1_val               = q1.val;
  assign bus.q2_ready             = q2.ready;
  assign bus.q2_val               = q2.val;
  // Pulses are masked while frozen so a stalled consumer never sees them twice.
  assign bus.rob_to_reg_commit    = commit_q && rdy_in;
  assign bus.rob_to_reg_rob_index = commit_idx_q;
  assign bus.rob_to_reg_index     = commit_rd_q;
  assign bus.rob_to_reg_val       = commit_val_q;
  assign bus.rob_flush            = flush_q && rdy_in;
  assign bus.rob_flush_pc         = flush_pc_q;

  // Issuing into a full buffer is an upstream bug; the request is dropped.
  issue_when_full_a: assert property (@(posedge clk_in) disable iff (rst_in)
    !(rdy_in && bus.issue_valid && full));

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  reorder_buffer_if rob_bus ();

  reorder_buffer dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (rob_bus)
  );

  always #5 clk = ~clk;

  // Model: live entries in program order; head is the front, tail is the next index handed out.
  typedef struct {
    int          idx;
    logic [4:0]  rd;
    logic        br;
    logic        pred;
    logic        taken;
    logic        ready;
    logic [31:0] val;
    logic [31:0] alt;
  } ent_t;

  ent_t        mq[$];
  int          m_tail;
  logic        m_commit, m_flush;
  int          m_cidx;
  logic [4:0]  m_crd;
  logic [31:0] m_cval, m_fpc;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int m_head();
    return (mq.size() == 0) ? m_tail : mq[0].idx;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_tail   = 1;
    m_commit = 1'b0;
    m_flush  = 1'b0;
  endtask

  function automatic logic [32:0] model_query(input logic [3:0] idx);
    if (idx == 4'd0) return 33'd0;
    if (rob_bus.alu_valid && rob_bus.alu_rob_index == idx) return {1'b1, rob_bus.alu_val};
    if (rob_bus.lsb_valid && rob_bus.lsb_rob_index == idx) return {1'b1, rob_bus.lsb_val};
    foreach (mq[i]) if (mq[i].idx == int'(idx)) return {mq[i].ready, mq[i].val};
    return 33'd0;
  endfunction

  // Apply the current inputs to the model as the coming clock edge would.
  task automatic model_step();
    bit   was_full, mis;
    ent_t e;
    if (!rdy) return;
    was_full = (mq.size() == 15);
    foreach (mq[i]) begin
      if (rob_bus.alu_valid && int'(rob_bus.alu_rob_index) == mq[i].idx) begin
        mq[i].ready = 1'b1;
        mq[i].val   = rob_bus.alu_val;
        mq[i].taken = rob_bus.alu_taken;
      end else if (rob_bus.lsb_valid && int'(rob_bus.lsb_rob_index) == mq[i].idx) begin
        mq[i].ready = 1'b1;
        mq[i].val   = rob_bus.lsb_val;
      end
    end
    m_commit = 1'b0;
    m_flush  = 1'b0;
    mis      = 1'b0;
    if (mq.size() != 0 && mq[0].ready) begin
      m_commit = 1'b1;
      m_cidx   = mq[0].idx;
      m_crd    = mq[0].rd;
      m_cval   = mq[0].val;
      mis      = mq[0].br && (mq[0].taken != mq[0].pred);
      if (mis) begin
        m_flush = 1'b1;
        m_fpc   = mq[0].alt;
      end
      void'(mq.pop_front());
    end
    if (mis) begin
      mq.delete();
      m_tail = 1;
    end else if (rob_bus.issue_valid && !was_full) begin
      e = '{idx: m_tail, rd: rob_bus.issue_rd, br: rob_bus.issue_is_branch,
            pred: rob_bus.issue_pred_taken, taken: 1'b0, ready: 1'b0, val: 32'd0,
            alt: rob_bus.issue_alt_pc};
      mq.push_back(e);
      m_tail = (m_tail == 15) ? 1 : m_tail + 1;
    end
  endtask

  task automatic check_query();
    logic [32:0] e1, e2;
    e1 = model_query(rob_bus.q1_index);
    e2 = model_query(rob_bus.q2_index);
    check("q1_ready", rob_bus.q1_ready, e1[32]);
    if (e1[32] || rob_bus.q1_index == 4'd0) check("q1_val", rob_bus.q1_val, e1[31:0]);
    check("q2_ready", rob_bus.q2_ready, e2[32]);
    if (e2[32] || rob_bus.q2_index == 4'd0) check("q2_val", rob_bus.q2_val, e2[31:0]);
  endtask

  task automatic check_outputs();
    check("commit", rob_bus.rob_to_reg_commit, rdy && m_commit);
    if (rdy && m_commit) begin
      check("commit_rob_index", rob_bus.rob_to_reg_rob_index, m_cidx);
      check("commit_rd", rob_bus.rob_to_reg_index, m_crd);
      check("commit_val", rob_bus.rob_to_reg_val, m_cval);
    end
    check("flush", rob_bus.rob_flush, rdy && m_flush);
    if (rdy && m_flush) check("flush_pc", rob_bus.rob_flush_pc, m_fpc);
    check("head", rob_bus.rob_head_index, m_head());
    check("alloc", rob_bus.rob_alloc_index, m_tail);
    check("full", rob_bus.rob_full, mq.size() == 15);
  endtask

  // One clock: combinational checks mid-cycle, then registered checks just after the edge.
  task automatic cycle();
    @(negedge clk);
    check_query();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    rob_bus.issue_valid      = 1'b0;
    rob_bus.issue_rd         = '0;
    rob_bus.issue_is_branch  = 1'b0;
    rob_bus.issue_pred_taken = 1'b0;
    rob_bus.issue_alt_pc     = '0;
    rob_bus.alu_valid        = 1'b0;
    rob_bus.alu_rob_index    = '0;
    rob_bus.alu_val          = '0;
    rob_bus.alu_taken        = 1'b0;
    rob_bus.lsb_valid        = 1'b0;
    rob_bus.lsb_rob_index    = '0;
    rob_bus.lsb_val          = '0;
    rob_bus.q1_index         = '0;
    rob_bus.q2_index         = '0;
  endtask

  task automatic set_issue(input logic [4:0] rd, input logic br, input logic pred,
                           input logic [31:0] alt);
    rob_bus.issue_valid      = 1'b1;
    rob_bus.issue_rd         = rd;
    rob_bus.issue_is_branch  = br;
    rob_bus.issue_pred_taken = pred;
    rob_bus.issue_alt_pc     = alt;
  endtask

  task automatic check_reset_outputs();
    check("rst_commit", rob_bus.rob_to_reg_commit, 1'b0);
    check("rst_rob_index", rob_bus.rob_to_reg_rob_index, 0);
    check("rst_reg_index", rob_bus.rob_to_reg_index, 0);
    check("rst_val", rob_bus.rob_to_reg_val, 0);
    check("rst_flush", rob_bus.rob_flush, 1'b0);
    check("rst_flush_pc", rob_bus.rob_flush_pc, 0);
    check("rst_head", rob_bus.rob_head_index, 1);
    check("rst_alloc", rob_bus.rob_alloc_index, 1);
    check("rst_full", rob_bus.rob_full, 1'b0);
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    idle_inputs();
    rdy = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [3:0] pick_index();
    if (mq.size() != 0 && $urandom_range(0, 7) != 0)
      return 4'(mq[$urandom_range(0, mq.size() - 1)].idx);
    return 4'($urandom_range(1, 15));
  endfunction

  task automatic random_inputs();
    idle_inputs();
    rdy = ($urandom_range(0, 9) != 0);
    if (mq.size() < 15 && $urandom_range(0, 3) != 0)
      set_issue(5'($urandom_range(0, 31)), ($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 1)), $urandom);
    if ($urandom_range(0, 2) == 0) begin
      rob_bus.alu_valid     = 1'b1;
      rob_bus.alu_rob_index = pick_index();
      rob_bus.alu_val       = $urandom;
      rob_bus.alu_taken     = 1'($urandom_range(0, 1));
    end
    if ($urandom_range(0, 2) == 0) begin
      rob_bus.lsb_valid     = 1'b1;
      rob_bus.lsb_rob_index = pick_index();
      rob_bus.lsb_val       = $urandom;
      if (rob_bus.alu_valid && rob_bus.alu_rob_index == rob_bus.lsb_rob_index)
        rob_bus.lsb_valid = 1'b0;
    end
    rob_bus.q1_index = 4'($urandom_range(0, 15));
    rob_bus.q2_index = 4'($urandom_range(0, 15));
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single issue and result: commit pulse the cycle after the result.
    check("t1_alloc", rob_bus.rob_alloc_index, 1);
    set_issue(5'd5, 1'b0, 1'b0, 32'h0);
    cycle();
    idle_inputs();
    rob_bus.alu_valid     = 1'b1;
    rob_bus.alu_rob_index = 4'd1;
    rob_bus.alu_val       = 32'h1234;
    cycle();
    check("t1_commit", rob_bus.rob_to_reg_commit, 1'b1);
    check("t1_reg_index", rob_bus.rob_to_reg_index, 5);
    check("t1_rob_index", rob_bus.rob_to_reg_rob_index, 1);
    check("t1_val", rob_bus.rob_to_reg_val, 32'h1234);
    idle_inputs();
    cycle();

    // Out-of-order results retire in order.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      set_issue(5'(i), 1'b0, 1'b0, 32'h0);
      cycle();
    end
    idle_inputs();
    rob_bus.alu_valid = 1'b1; rob_bus.alu_rob_index = 4'd3; rob_bus.alu_val = 32'h33;
    cycle();
    check("ooo_no_commit", rob_bus.rob_to_reg_commit, 1'b0);
    rob_bus.alu_rob_index = 4'd1; rob_bus.alu_val = 32'h11;
    cycle();
    check("ooo_commit1", rob_bus.rob_to_reg_rob_index, 1);
    idle_inputs();
    rob_bus.lsb_valid = 1'b1; rob_bus.lsb_rob_index = 4'd2; rob_bus.lsb_val = 32'h22;
    cycle();
    check("ooo_commit2", rob_bus.rob_to_reg_rob_index, 2);
    check("ooo_val2", rob_bus.rob_to_reg_val, 32'h22);
    idle_inputs();
    cycle();
    check("ooo_commit3", rob_bus.rob_to_reg_rob_index, 3);
    check("ooo_val3", rob_bus.rob_to_reg_val, 32'h33);

    // Fill to capacity, then retire one and reuse index 1.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      set_issue(5'(i + 1), 1'b0, 1'b0, 32'h0);
      cycle();
    end
    idle_inputs();
    check("fill_full", rob_bus.rob_full, 1'b1);
    check("fill_alloc_wrap", rob_bus.rob_alloc_index, 1);
    rob_bus.alu_valid = 1'b1; rob_bus.alu_rob_index = 4'd1; rob_bus.alu_val = 32'h99;
    cycle();
    check("fill_not_full", rob_bus.rob_full, 1'b0);
    idle_inputs();
    set_issue(5'd20, 1'b0, 1'b0, 32'h0);
    cycle();
    check("fill_alloc_after", rob_bus.rob_alloc_index, 2);
    check("fill_full_again", rob_bus.rob_full, 1'b1);

    // Mispredict: flush, pointer reset, same-cycle issue/result and later stale results dropped.
    do_reset();
    set_issue(5'd1, 1'b1, 1'b0, 32'h100);
    cycle();
    set_issue(5'd2, 1'b0, 1'b0, 32'h0);
    cycle();
    set_issue(5'd9, 1'b0, 1'b0, 32'h0);
    rob_bus.alu_valid = 1'b1; rob_bus.alu_rob_index = 4'd1;
    rob_bus.alu_val = 32'h44; rob_bus.alu_taken = 1'b1;
    rob_bus.lsb_valid = 1'b1; rob_bus.lsb_rob_index = 4'd2; rob_bus.lsb_val = 32'h55;
    cycle();
    check("misp_flush", rob_bus.rob_flush, 1'b1);
    check("misp_pc", rob_bus.rob_flush_pc, 32'h100);
    check("misp_commit", rob_bus.rob_to_reg_commit, 1'b1);
    check("misp_rd", rob_bus.rob_to_reg_index, 1);
    check("misp_head", rob_bus.rob_head_index, 1);
    check("misp_alloc", rob_bus.rob_alloc_index, 1);
    idle_inputs();
    rob_bus.lsb_valid = 1'b1; rob_bus.lsb_rob_index = 4'd2; rob_bus.lsb_val = 32'h66;
    cycle();
    check("misp_flush_drop", rob_bus.rob_flush, 1'b0);
    idle_inputs();
    rob_bus.q1_index = 4'd2;
    #1;
    check("misp_stale_ready", rob_bus.q1_ready, 1'b0);
    cycle();

    // Bypass from the LSB bus in the same cycle.
    do_reset();
    set_issue(5'd1, 1'b0, 1'b0, 32'h0);
    cycle();
    set_issue(5'd2, 1'b0, 1'b0, 32'h0);
    cycle();
    idle_inputs();
    rob_bus.q1_index = 4'd2;
    rob_bus.lsb_valid = 1'b1; rob_bus.lsb_rob_index = 4'd2; rob_bus.lsb_val = 32'hAB;
    #1;
    check("byp_ready", rob_bus.q1_ready, 1'b1);
    check("byp_val", rob_bus.q1_val, 32'hAB);
    check("byp_null_ready", rob_bus.q2_ready, 1'b0);
    cycle();

    // Freeze with a result pending at head.
    do_reset();
    set_issue(5'd7, 1'b0, 1'b0, 32'h0);
    cycle();
    idle_inputs();
    cycle();
    rdy = 1'b0;
    rob_bus.alu_valid = 1'b1; rob_bus.alu_rob_index = 4'd1; rob_bus.alu_val = 32'h77;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("frz_commit", rob_bus.rob_to_reg_commit, 1'b0);
      check("frz_head", rob_bus.rob_head_index, 1);
      check("frz_alloc", rob_bus.rob_alloc_index, 2);
    end
    rdy = 1'b1;
    cycle();
    check("frz_release_commit", rob_bus.rob_to_reg_commit, 1'b1);
    check("frz_release_val", rob_bus.rob_to_reg_val, 32'h77);

    // Random traffic, asynchronous reset mid-stream, more random traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      random_inputs();
      cycle();
    end
    do_reset();
    for (int i = 0; i < 600; i++) begin
      random_inputs();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement queue for the Tomasulo core.
- Allocates a ROB index per issued instruction and captures results from the ALU and LSB result buses.
- Drives the register-file commit interface (rob_to_reg_*), which the register file consumes to clear rename dependencies.
- Detects branch mispredicts at retirement and issues a pipeline flush with the redirect PC.

Parameters:
- ROB_SIZE, 16, physical slots. Index 0 is reserved to mean "no dependency", so slots 1..ROB_SIZE-1 are usable (15 entries).
- ROB_IDX_W, 4, width of a ROB index; equals log2(ROB_SIZE).

Ports:
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- rdy_in  in  1  global enable; 0 freezes all state.
- issue_valid  in  1  allocate one entry this cycle.
- issue_rd  in  5  destination register; 0 = no register write.
- issue_is_branch  in  1  entry is a conditional branch or JALR.
- issue_pred_taken  in  1  predicted direction.
- issue_alt_pc  in  32  PC to redirect to if the prediction is wrong.
- rob_full  out  1  no free slot; issue must not assert.
- rob_alloc_index  out  ROB_IDX_W  index the next issue receives (tail).
- alu_valid / alu_rob_index / alu_val / alu_taken  in  1/ROB_IDX_W/32/1  ALU result bus.
- lsb_valid / lsb_rob_index / lsb_val  in  1/ROB_IDX_W/32  load/store result bus.
- q1_index, q2_index  in  ROB_IDX_W  operand lookup from the decoder.
- q1_ready, q2_ready  out  1  value available.
- q1_val, q2_val  out  32  value for the looked-up entry.
- rob_to_reg_commit  out  1  one-cycle commit pulse.
- rob_to_reg_rob_index  out  ROB_IDX_W  index of the retiring entry.
- rob_to_reg_index  out  5  destination register.
- rob_to_reg_val  out  32  result value.
- rob_head_index  out  ROB_IDX_W  oldest entry; the LSB uses it to release stores.
- rob_flush  out  1  mispredict flush pulse.
- rob_flush_pc  out  32  redirect target.

Behaviour:
- Per-entry fields: busy, ready, rd, val, is_branch, pred_taken, actual_taken, alt_pc. Pointers head and tail, plus a count.
- Reset (async) and flush state:
  - head = tail = 1, count = 0, all busy and ready bits = 0.
  - All outputs 0, except rob_alloc_index = 1 and rob_head_index = 1.
- rdy_in = 0: no state change; rob_to_reg_commit and rob_flush are driven 0.
- Pointer increment: wraps from ROB_SIZE-1 to 1 and never produces index 0.
- rob_full = (count == ROB_SIZE-1). This is combinational from registered count, so a commit in the same cycle does not clear it.
- Issue, when issue_valid && !rob_full:
  - Write the entry at tail with busy = 1, ready = 0, and the issue fields.
  - Advance tail; count += 1.
  - If issue_valid is asserted while full, ignore it (verification flags this as an assertion).
- Result capture, each bus independently:
  - If valid and the target entry is busy, set ready = 1 and store val; ALU also stores actual_taken.
  - Writes to non-busy entries are dropped.
  - Both buses targeting the same index in one cycle is illegal; if it happens, ALU wins.
- Query (combinational):
  - q_ready = entry.ready, or a matching valid result on either bus this cycle (bypass).
  - q_val comes from the bus when bypassing, otherwise from the entry.
  - An index of 0 returns ready = 0 and val = 0.
- Commit: at most one per cycle, when head is busy and ready.
  - Next cycle: rob_to_reg_commit = 1 with the entry's index, rd and val, even when rd = 0. The register file ignores x0.
  - Clear busy; advance head; count -= 1.
  - A commit and an issue in the same cycle leave count unchanged.
- Mispredict (committing entry has is_branch and actual_taken != pred_taken):
  - The same commit pulse is produced, so a JALR still writes rd.
  - rob_flush = 1 with rob_flush_pc = alt_pc, registered in the same cycle as the commit pulse.
  - All entries are invalidated and the pointers reset as on reset.
  - Any issue or result in that cycle is discarded.
- Latency:
  - Result arrival to commit pulse: one cycle minimum, when the entry is at head.
  - Issue to earliest commit: two cycles.

Decomposition:
- Add to def.v: ROB_SIZE, ROB_INDEX_TYPE ([ROB_IDX_W-1:0]), REG_INDEX_TYPE, DATA_TYPE, ADDR_TYPE, and a ROB_NULL_INDEX = 0 constant.
- Keep one flat module. A small wrap-increment function is sufficient; no sub-module is needed.

Test Plan:
- Reset, issue rd = 5 at index 1, ALU result idx 1 val 0x1234 → next cycle commit = 1, reg_index = 5, rob_index = 1, val = 0x1234.
- Out-of-order results:
  - Stimulus: issue three entries (idx 1, 2, 3); results arrive in order 3, 1, 2.
  - Required response: commits in order 1, 2, 3 on consecutive cycles after idx 2 is ready.
- Fill and wrap:
  - Issue 15 entries → rob_full = 1 and rob_alloc_index wraps 15 → 1.
  - Retire one and issue one → the new entry receives index 1 and index 0 is never produced.
- Mispredict: branch pred_taken = 0, alt_pc 0x100, ALU taken = 1 → rob_flush = 1 with pc 0x100, then head = tail = 1 and count = 0; results to old indices are dropped.
- Bypass: q1_index = 2 while LSB writes idx 2 val 0xAB that cycle → q1_ready = 1, q1_val = 0xAB combinationally.
- Freeze and reset:
  - Hold rdy_in = 0 with a ready head → no commit and state frozen.
  - Assert rst_in mid-stream, asynchronously to the clock → outputs clear immediately.
